// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler: FSM state encoding.
package rr_sched_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } st_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority first-one search: the lower copy of req is masked below ptr, the
// upper copy is unmasked, so the first hit in the doubled vector is the round-robin winner.
module rr_priority_pick #(
  parameter int unsigned REQ_NUM_W = 3,
  parameter int unsigned NUM_REQ   = 1 << REQ_NUM_W
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_NUM_W-1:0] ptr,
  output logic                 any,
  output logic [REQ_NUM_W-1:0] idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic                 found;

  always_comb begin
    dbl = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      dbl[i]           = req[i] && (i >= int'(ptr));
      dbl[NUM_REQ + i] = req[i];
    end
  end

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * int'(NUM_REQ); i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = (i >= int'(NUM_REQ)) ? REQ_NUM_W'(i - int'(NUM_REQ)) : REQ_NUM_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: picks a requester, offers it with valid/ready, and holds
// ownership until done_i. Grant is exposed as a binary index and a one-hot vector.
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned REQ_NUM_W = 3,
  parameter int unsigned NUM_REQ   = 1 << REQ_NUM_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic                 gnt_valid_o,
  input  logic                 gnt_ready_i,
  input  logic                 done_i,
  output logic [REQ_NUM_W-1:0] gnt_idx_o,
  output logic [NUM_REQ-1:0]   gnt_onehot_o,
  output logic                 busy_o
);

  localparam logic [REQ_NUM_W-1:0] LastIdx = REQ_NUM_W'(NUM_REQ - 1);

  st_e                  state_q;
  logic [REQ_NUM_W-1:0] ptr_q;
  logic [REQ_NUM_W-1:0] idx_q;
  logic                 pick_any;
  logic [REQ_NUM_W-1:0] pick_idx;

  rr_priority_pick #(
    .REQ_NUM_W(REQ_NUM_W),
    .NUM_REQ  (NUM_REQ)
  ) u_pick (
    .req(req_i),
    .ptr(ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            idx_q   <= pick_idx;
            state_q <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          // Pointer moves past the accepted owner so it gets lowest priority next time.
          if (gnt_ready_i) begin
            state_q <= ST_BUSY;
            ptr_q   <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          end
        end
        ST_BUSY: begin
          if (done_i) begin
            if (pick_any) begin
              idx_q   <= pick_idx;
              state_q <= ST_OFFER;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt_valid_o = (state_q == ST_OFFER);
  assign busy_o      = (state_q == ST_BUSY);
  assign gnt_idx_o   = idx_q;

  always_comb begin
    gnt_onehot_o = '0;
    if (state_q != ST_IDLE) gnt_onehot_o[idx_q] = 1'b1;
  end

endmodule
